// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - perceptron weight trainer: decides on training and
// performs a serial read-modify-write of one weight row in the shared weight RAM.
module perceptron_trainer #(
  parameter  int HIST_LEN = 8,
  parameter  int WEIGHT_W = 8,
  parameter  int IDX_W    = 6,
  parameter  int THETA    = 29,
  localparam int SEL_W    = $clog2(HIST_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resolve_valid,
  output logic                resolve_ready,
  input  logic [IDX_W-1:0]    resolve_idx,
  input  logic [HIST_LEN-1:0] resolve_ghr,
  input  logic [7:0]          resolve_y_out,
  input  logic                resolve_pred,
  input  logic                resolve_taken,
  output logic [IDX_W-1:0]    wt_addr,
  output logic [SEL_W-1:0]    wt_sel,
  output logic                wt_read,
  input  logic [WEIGHT_W-1:0] wt_rdata,
  output logic                wt_write,
  output logic [WEIGHT_W-1:0] wt_wdata,
  output logic                busy,
  output logic [15:0]         train_count,
  output logic [15:0]         mispred_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [8:0]       THETA_MAG = 9'(THETA);
  localparam logic [SEL_W-1:0] LAST_COL  = SEL_W'(HIST_LEN);

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx_q;
  logic [HIST_LEN-1:0] ghr_q;
  logic                taken_q;
  logic [SEL_W-1:0]    col;

  logic                accept;
  logic                mispredict;
  logic [8:0]          y_mag;
  logic                train;

  assign accept     = resolve_valid && (state == S_IDLE);
  assign mispredict = resolve_pred != resolve_taken;
  // 9-bit magnitude so that -128 maps to +128 rather than wrapping
  assign y_mag      = resolve_y_out[7] ? (9'd0 - {1'b1, resolve_y_out}) : {1'b0, resolve_y_out};
  assign train      = mispredict || (y_mag <= THETA_MAG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      idx_q         <= '0;
      ghr_q         <= '0;
      taken_q       <= 1'b0;
      col           <= '0;
      train_count   <= '0;
      mispred_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_q   <= resolve_idx;
            ghr_q   <= resolve_ghr;
            taken_q <= resolve_taken;
            col     <= '0;
            if (mispredict && (mispred_count != 16'hFFFF))
              mispred_count <= mispred_count + 16'd1;
            if (train && (train_count != 16'hFFFF))
              train_count <= train_count + 16'd1;
            if (train)
              state <= S_READ;
          end
        end
        S_READ: state <= S_WRITE;
        S_WRITE: begin
          if (col == LAST_COL) begin
            state <= S_IDLE;
          end else begin
            col   <= col + 1'b1;
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Column 0 is the bias, whose input is always +1
  logic [HIST_LEN:0]   x_vec;
  logic                d_pos;
  logic [WEIGHT_W:0]   sum;
  logic [WEIGHT_W-1:0] sat;

  assign x_vec = {ghr_q, 1'b1};
  assign d_pos = x_vec[col] == taken_q;
  assign sum   = {wt_rdata[WEIGHT_W-1], wt_rdata} + (d_pos ? (WEIGHT_W+1)'(1) : {(WEIGHT_W+1){1'b1}});

  always_comb begin
    sat = sum[WEIGHT_W-1:0];
    if (sum[WEIGHT_W] != sum[WEIGHT_W-1])
      sat = sum[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}} : {1'b0, {(WEIGHT_W-1){1'b1}}};
  end

  assign resolve_ready = state == S_IDLE;
  assign wt_read       = state == S_READ;
  assign wt_write      = state == S_WRITE;
  assign busy          = wt_read || wt_write;
  assign wt_addr       = busy ? idx_q : '0;
  assign wt_sel        = busy ? col : '0;
  assign wt_wdata      = wt_write ? sat : '0;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - randomized self-checking bench for perceptron_trainer
// with a behavioural weight RAM and an arithmetic reference model of training.
module tb_perceptron_trainer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resolve_valid = 1'b0;
  logic        resolve_ready;
  logic [5:0]  resolve_idx = '0;
  logic [7:0]  resolve_ghr = '0;
  logic [7:0]  resolve_y_out = '0;
  logic        resolve_pred = 1'b0;
  logic        resolve_taken = 1'b0;
  logic [5:0]  wt_addr;
  logic [3:0]  wt_sel;
  logic        wt_read;
  logic [7:0]  wt_rdata;
  logic        wt_write;
  logic [7:0]  wt_wdata;
  logic        busy;
  logic [15:0] train_count;
  logic [15:0] mispred_count;

  perceptron_trainer dut (
    .clk(clk), .rst(rst),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_idx(resolve_idx), .resolve_ghr(resolve_ghr), .resolve_y_out(resolve_y_out),
    .resolve_pred(resolve_pred), .resolve_taken(resolve_taken),
    .wt_addr(wt_addr), .wt_sel(wt_sel), .wt_read(wt_read), .wt_rdata(wt_rdata),
    .wt_write(wt_write), .wt_wdata(wt_wdata), .busy(busy),
    .train_count(train_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  // Weight RAM: one-cycle read latency, plus a whole-row preload port for the bench
  logic [7:0] mem [64][9];
  logic       ld_en = 1'b0;
  logic [5:0] ld_idx = '0;
  logic [7:0] ld_row [9];

  always @(posedge clk) begin
    if (ld_en)
      for (int c = 0; c < 9; c++) mem[ld_idx][c] <= ld_row[c];
    if (wt_read) wt_rdata <= mem[wt_addr][wt_sel];
    if (wt_write) mem[wt_addr][wt_sel] <= wt_wdata;
  end

  int checks = 0;
  int failures = 0;
  int ref_mem [64][9];
  int exp_train = 0;
  int exp_mis = 0;

  function automatic int clamp(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Reference: returns whether training happens and applies w += t*x to the model row
  function automatic bit model_accept(input int idx, input logic [7:0] ghr, input int y,
                                      input bit pred, input bit taken);
    bit mis;
    bit tr;
    int mag;
    int t;
    int x;
    mis = pred != taken;
    mag = (y < 0) ? -y : y;
    tr  = mis || (mag <= 29);
    if (mis && exp_mis < 65535) exp_mis++;
    if (tr && exp_train < 65535) exp_train++;
    if (tr) begin
      t = taken ? 1 : -1;
      for (int c = 0; c < 9; c++) begin
        x = (c == 0) ? 1 : (ghr[c-1] ? 1 : -1);
        ref_mem[idx][c] = clamp(ref_mem[idx][c] + t * x);
      end
    end
    return tr;
  endfunction

  task automatic preload(input int idx, input int v[9]);
    @(negedge clk);
    ld_idx = idx[5:0];
    for (int c = 0; c < 9; c++) begin
      ld_row[c] = v[c][7:0];
      ref_mem[idx][c] = v[c];
    end
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic random_row(input int idx);
    int v[9];
    for (int c = 0; c < 9; c++) begin
      case ($urandom_range(0, 3))
        0: v[c] = 127;
        1: v[c] = -128;
        default: v[c] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
    preload(idx, v);
  endtask

  task automatic drive(input int idx, input logic [7:0] ghr, input int y, input bit pred, input bit taken);
    resolve_idx   = idx[5:0];
    resolve_ghr   = ghr;
    resolve_y_out = y[7:0];
    resolve_pred  = pred;
    resolve_taken = taken;
    resolve_valid = 1'b1;
  endtask

  // Counts non-ready cycles after an accept and flags strobe-rule violations
  task automatic watch(output int cycles, output bit bad, output bit any_strobe);
    cycles = 0; bad = 1'b0; any_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (wt_read || wt_write) any_strobe = 1'b1;
      if (wt_read && wt_write) bad = 1'b1;
      if (!busy && (wt_read || wt_write || wt_wdata != 8'd0)) bad = 1'b1;
      if (busy == resolve_ready) bad = 1'b1;
      if (resolve_ready) break;
      cycles++;
      if (cycles > 60) break;
    end
  endtask

  task automatic do_branch(input int idx, input logic [7:0] ghr, input int y, input bit pred,
                           input bit taken, output bit tr, output int cycles, output bit bad,
                           output bit any_strobe);
    @(negedge clk);
    drive(idx, ghr, y, pred, taken);
    @(posedge clk);
    #1 resolve_valid = 1'b0;
    tr = model_accept(idx, ghr, y, pred, taken);
    watch(cycles, bad, any_strobe);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++;
    if ({resolve_ready, busy, wt_read, wt_write} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000", {resolve_ready, busy, wt_read, wt_write});
    end
    checks++;
    if ({wt_wdata, wt_addr, wt_sel} !== 18'd0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {wt_wdata, wt_addr, wt_sel});
    end
    checks++;
    if ({train_count, mispred_count} !== 32'd0) begin
      failures++;
      $display("FAIL reset_counts got=%h exp=0", {train_count, mispred_count});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_train;
    bit tr, bad, anys;
    int cyc;
    do_branch(3, 8'h3C, 60, 1'b1, 1'b1, tr, cyc, bad, anys);
    checks++;
    if (cyc != 0 || anys || bad) begin
      failures++;
      $display("FAIL no_train got cycles=%0d strobes=%0b bad=%0b exp 0/0/0", cyc, anys, bad);
    end
    checks++;
    if (train_count !== 16'(exp_train) || mispred_count !== 16'(exp_mis) || exp_train != 0) begin
      failures++;
      $display("FAIL no_train_counts got=%0d/%0d exp=0/0", train_count, mispred_count);
    end
  endtask

  task automatic test_low_conf;
    bit tr, bad, anys;
    int cyc;
    int z[9] = '{default: 0};
    int lit[9] = '{1, 1, -1, 1, -1, -1, 1, -1, 1};
    preload(5, z);
    do_branch(5, 8'b1010_0101, 29, 1'b1, 1'b1, tr, cyc, bad, anys);
    checks++;
    if (cyc != 18 || bad) begin
      failures++;
      $display("FAIL low_conf_latency got=%0d bad=%0b exp=18", cyc, bad);
    end
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (mem[5][c] !== 8'(lit[c]) || lit[c] != ref_mem[5][c]) begin
        failures++;
        $display("FAIL low_conf_col%0d got=%0d exp=%0d", c, $signed(mem[5][c]), lit[c]);
      end
    end
    checks++;
    if (train_count !== 16'd1 || mispred_count !== 16'd0) begin
      failures++;
      $display("FAIL low_conf_counts got=%0d/%0d exp=1/0", train_count, mispred_count);
    end
  endtask

  task automatic test_mispredict;
    bit tr, bad, anys;
    int cyc;
    int v[9] = '{5, 0, 1, -1, 10, -10, 100, -100, 3};
    preload(9, v);
    do_branch(9, 8'($urandom), -128, 1'b0, 1'b1, tr, cyc, bad, anys);
    checks++;
    if (cyc != 18 || !tr) begin
      failures++;
      $display("FAIL mispred_latency got=%0d exp=18", cyc);
    end
    checks++;
    if (mem[9][0] !== 8'd6) begin
      failures++;
      $display("FAIL mispred_bias got=%0d exp=6", $signed(mem[9][0]));
    end
    for (int c = 1; c < 9; c++) begin
      checks++;
      if (mem[9][c] !== 8'(ref_mem[9][c])) begin
        failures++;
        $display("FAIL mispred_col%0d got=%0d exp=%0d", c, $signed(mem[9][c]), ref_mem[9][c]);
      end
    end
    checks++;
    if (train_count !== 16'd2 || mispred_count !== 16'd1) begin
      failures++;
      $display("FAIL mispred_counts got=%0d/%0d exp=2/1", train_count, mispred_count);
    end
  endtask

  task automatic test_saturation;
    bit tr, bad, anys;
    int cyc;
    int v[9] = '{127, -128, -128, 127, -128, 0, 0, 0, 0};
    int lit[5] = '{127, -128, -127, 127, -128};
    preload(12, v);
    do_branch(12, 8'b0000_0110, 0, 1'b1, 1'b1, tr, cyc, bad, anys);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (mem[12][c] !== 8'(lit[c]) || lit[c] != ref_mem[12][c]) begin
        failures++;
        $display("FAIL sat_col%0d got=%0d exp=%0d", c, $signed(mem[12][c]), lit[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit bad, anys, tr;
    random_row(20);
    random_row(21);
    @(negedge clk);
    drive(20, 8'($urandom), 10, 1'b0, 1'b0);
    @(posedge clk);
    tr = model_accept(20, resolve_ghr, 10, 1'b0, 1'b0);
    #1 drive(21, 8'($urandom), -5, 1'b1, 1'b1);
    cyc = 0;
    repeat (60) begin
      @(negedge clk);
      if (resolve_ready) break;
      cyc++;
      if (cyc == 9) begin
        checks++;
        if (train_count !== 16'(exp_train) || mispred_count !== 16'(exp_mis)) begin
          failures++;
          $display("FAIL b2b_counts_busy got=%0d/%0d exp=%0d/%0d", train_count, mispred_count, exp_train, exp_mis);
        end
      end
    end
    checks++;
    if (cyc != 18) begin
      failures++;
      $display("FAIL b2b_ready_low got=%0d exp=18", cyc);
    end
    @(posedge clk);
    tr = model_accept(21, resolve_ghr, -5, 1'b1, 1'b1);
    #1 resolve_valid = 1'b0;
    watch(cyc, bad, anys);
    checks++;
    if (cyc != 18 || bad) begin
      failures++;
      $display("FAIL b2b_second got=%0d bad=%0b exp=18", cyc, bad);
    end
    for (int r = 20; r < 22; r++)
      for (int c = 0; c < 9; c++) begin
        checks++;
        if (mem[r][c] !== 8'(ref_mem[r][c])) begin
          failures++;
          $display("FAIL b2b_row%0d_col%0d got=%0d exp=%0d", r, c, $signed(mem[r][c]), ref_mem[r][c]);
        end
      end
    checks++;
    if (train_count !== 16'(exp_train) || mispred_count !== 16'(exp_mis)) begin
      failures++;
      $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", train_count, mispred_count, exp_train, exp_mis);
    end
  endtask

  task automatic test_random;
    int ys[6] = '{29, 30, -29, -30, -128, 127};
    bit tr, bad, anys, pred, taken;
    int cyc, idx, y;
    for (int n = 0; n < 16; n++) begin
      idx   = int'($urandom_range(32, 63));
      y     = (n < 6) ? ys[n] : int'($urandom_range(0, 255)) - 128;
      pred  = 1'($urandom);
      taken = (n < 6) ? pred : 1'($urandom);
      random_row(idx);
      do_branch(idx, 8'($urandom), y, pred, taken, tr, cyc, bad, anys);
      checks++;
      if (cyc != (tr ? 18 : 0) || bad || anys != tr) begin
        failures++;
        $display("FAIL rand%0d_timing y=%0d got=%0d bad=%0b exp=%0d", n, y, cyc, bad, tr ? 18 : 0);
      end
      for (int c = 0; c < 9; c++) begin
        checks++;
        if (mem[idx][c] !== 8'(ref_mem[idx][c])) begin
          failures++;
          $display("FAIL rand%0d_col%0d got=%0d exp=%0d", n, c, $signed(mem[idx][c]), ref_mem[idx][c]);
        end
      end
      checks++;
      if (train_count !== 16'(exp_train) || mispred_count !== 16'(exp_mis)) begin
        failures++;
        $display("FAIL rand%0d_counts got=%0d/%0d exp=%0d/%0d", n, train_count, mispred_count, exp_train, exp_mis);
      end
    end
  endtask

  task automatic test_reset_mid;
    int orig[9];
    int cyc;
    bit tr, found;
    logic [7:0] g;
    random_row(30);
    for (int c = 0; c < 9; c++) orig[c] = ref_mem[30][c];
    g = 8'($urandom);
    @(negedge clk);
    drive(30, g, 3, 1'b0, 1'b1);
    @(posedge clk);
    #1 resolve_valid = 1'b0;
    tr = model_accept(30, g, 3, 1'b0, 1'b1);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (wt_read && wt_sel == 4'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_col3_read got=not_seen exp=seen");
    end
    #1 rst = 1'b0;
    #1;
    exp_train = 0;
    exp_mis = 0;
    checks++;
    if ({resolve_ready, busy, wt_read, wt_write} !== 4'b1000 || wt_wdata !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got=%b/%0d exp=1000/0", {resolve_ready, busy, wt_read, wt_write}, wt_wdata);
    end
    checks++;
    if (train_count !== 16'(exp_train) || mispred_count !== 16'(exp_mis)) begin
      failures++;
      $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", train_count, mispred_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int c = 3; c < 9; c++) ref_mem[30][c] = orig[c];
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (mem[30][c] !== 8'(ref_mem[30][c])) begin
        failures++;
        $display("FAIL rst_mid_col%0d got=%0d exp=%0d", c, $signed(mem[30][c]), ref_mem[30][c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_train();
    test_low_conf();
    test_mispredict();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
